// File: rtl/wb_stage_q.sv
// Write-back stage with an in-order commit queue.
// Entries from the memory stage are buffered, retired one per cycle in FIFO
// order to the register file, and forwarded to earlier stages while pending.
// An excepting or ERET head raises a one-cycle EXC pulse and then the queue
// is emptied and a one-cycle FLUSH bubble is inserted before running again.
module wb_stage_q #(
  parameter int         DW    = 32,
  parameter int         AW    = 5,
  parameter int         DEPTH = 2,
  parameter logic [4:0] NO_EX = 5'h1f
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          ms_to_ws_valid,
  output logic          ws_allowin,
  input  logic          ms_wen,
  input  logic [AW-1:0] ms_dest,
  input  logic [DW-1:0] ms_data,
  input  logic [DW-1:0] ms_pc,
  input  logic [4:0]    ms_ex_code,
  input  logic          ms_eret,
  input  logic          ms_slot,
  input  logic [DW-1:0] ms_badvaddr,
  input  logic          rf_ready,
  output logic          rf_we,
  output logic [AW-1:0] rf_waddr,
  output logic [DW-1:0] rf_wdata,
  input  logic [AW-1:0] fwd_raddr,
  output logic          fwd_hit,
  output logic [DW-1:0] fwd_data,
  output logic          ws_ex,
  output logic          ws_eret,
  output logic          ws_flush,
  output logic [4:0]    ws_ex_code,
  output logic [DW-1:0] ws_epc,
  output logic [DW-1:0] ws_badvaddr,
  output logic          ws_slot,
  output logic [DW-1:0] debug_wb_pc,
  output logic [3:0]    debug_wb_rf_wen,
  output logic [AW-1:0] debug_wb_rf_wnum,
  output logic [DW-1:0] debug_wb_rf_wdata
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {S_RUN, S_EXC, S_FLUSH} state_e;

  state_e           state_q, state_d;
  logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic [DEPTH-1:0] valid_q, valid_d;

  // Payload storage; no reset needed, occupancy is tracked by count/valid.
  logic          ent_wen_q   [DEPTH];
  logic [AW-1:0] ent_dest_q  [DEPTH];
  logic [DW-1:0] ent_data_q  [DEPTH];
  logic [DW-1:0] ent_pc_q    [DEPTH];
  logic [4:0]    ent_ex_q    [DEPTH];
  logic          ent_eret_q  [DEPTH];
  logic          ent_slot_q  [DEPTH];
  logic [DW-1:0] ent_bad_q   [DEPTH];

  logic          head_present, head_exc, retire, push, in_exc, exc_is_ex;
  logic          head_wen, head_eret, head_slot;
  logic [AW-1:0] head_dest;
  logic [DW-1:0] head_data, head_pc, head_bad;
  logic [4:0]    head_ex;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign head_wen  = ent_wen_q[head_q];
  assign head_dest = ent_dest_q[head_q];
  assign head_data = ent_data_q[head_q];
  assign head_pc   = ent_pc_q[head_q];
  assign head_ex   = ent_ex_q[head_q];
  assign head_eret = ent_eret_q[head_q];
  assign head_slot = ent_slot_q[head_q];
  assign head_bad  = ent_bad_q[head_q];

  // Only the head is ever evaluated; younger excepting entries simply wait.
  assign head_present = (count_q != '0);
  assign head_exc     = head_present && ((head_ex != NO_EX) || head_eret);
  assign retire       = (state_q == S_RUN) && head_present && !head_exc &&
                        (!head_wen || rf_ready);
  // resetn gates allowin so the output reads 0 while reset is held.
  assign ws_allowin   = resetn && (state_q == S_RUN) &&
                        ((count_q != FULL_CNT) || retire);
  assign push         = ms_to_ws_valid && ws_allowin;

  // Register-file write and trace port; destination 0 is never written.
  assign rf_we             = retire && head_wen && (head_dest != '0);
  assign rf_waddr          = rf_we ? head_dest : '0;
  assign rf_wdata          = rf_we ? head_data : '0;
  assign debug_wb_rf_wen   = {4{rf_we}};
  assign debug_wb_rf_wnum  = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;
  assign debug_wb_pc       = head_present ? head_pc : '0;

  // Exception record is only driven during the single EXC cycle.
  assign in_exc      = (state_q == S_EXC);
  assign exc_is_ex   = head_ex != NO_EX;
  assign ws_flush    = in_exc;
  assign ws_ex       = in_exc && exc_is_ex;
  assign ws_eret     = in_exc && !exc_is_ex && head_eret;
  assign ws_ex_code  = in_exc ? head_ex : NO_EX;
  assign ws_slot     = in_exc && head_slot;
  assign ws_badvaddr = in_exc ? head_bad : '0;
  assign ws_epc      = in_exc ? (head_slot ? head_pc - DW'(4) : head_pc) : '0;

  // Forwarding: scan oldest to youngest so the youngest match wins.
  always_comb begin
    logic [PW-1:0] idx;
    idx      = '0;
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_q + PW'(k);
      if (valid_q[idx] && ent_wen_q[idx] && (ent_dest_q[idx] == fwd_raddr) &&
          (ent_dest_q[idx] != '0) && (ent_ex_q[idx] == NO_EX) && !ent_eret_q[idx]) begin
        fwd_hit  = 1'b1;
        fwd_data = ent_data_q[idx];
      end
    end
  end

  // Next-state logic for the commit FSM and queue bookkeeping.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    valid_d = valid_q;
    case (state_q)
      S_RUN: begin
        // Retire is applied before push so a push into the freed slot at full wins.
        if (retire) begin
          valid_d[head_q] = 1'b0;
          head_d          = ptr_inc(head_q);
        end
        if (push) begin
          valid_d[tail_q] = 1'b1;
          tail_d          = ptr_inc(tail_q);
        end
        count_d = count_q + CW'(push) - CW'(retire);
        if (head_exc) state_d = S_EXC;
      end
      S_EXC: begin
        head_d  = '0;
        tail_d  = '0;
        count_d = '0;
        valid_d = '0;
        state_d = S_FLUSH;
      end
      S_FLUSH: state_d = S_RUN;
      default: state_d = S_RUN;
    endcase
  end

  // State, pointer and occupancy registers with asynchronous clear.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_RUN;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  // Capture the incoming entry at the tail slot.
  always_ff @(posedge clk) begin
    if (push) begin
      ent_wen_q[tail_q]  <= ms_wen;
      ent_dest_q[tail_q] <= ms_dest;
      ent_data_q[tail_q] <= ms_data;
      ent_pc_q[tail_q]   <= ms_pc;
      ent_ex_q[tail_q]   <= ms_ex_code;
      ent_eret_q[tail_q] <= ms_eret;
      ent_slot_q[tail_q] <= ms_slot;
      ent_bad_q[tail_q]  <= ms_badvaddr;
    end
  end

endmodule

// File: tb/tb_wb_stage_q.sv
// Testbench for wb_stage_q: directed scenarios then random traffic, all
// checked against a queue-based reference model of the commit rules.
module tb_wb_stage_q;
  localparam int         DW    = 32;
  localparam int         AW    = 5;
  localparam int         DEPTH = 2;
  localparam logic [4:0] NO_EX = 5'h1f;

  logic          clk = 1'b0;
  logic          resetn;
  logic          ms_to_ws_valid, ws_allowin, ms_wen, ms_eret, ms_slot;
  logic [AW-1:0] ms_dest, rf_waddr, fwd_raddr, debug_wb_rf_wnum;
  logic [DW-1:0] ms_data, ms_pc, ms_badvaddr, rf_wdata, fwd_data;
  logic [4:0]    ms_ex_code, ws_ex_code;
  logic          rf_ready, rf_we, fwd_hit, ws_ex, ws_eret, ws_flush, ws_slot;
  logic [DW-1:0] ws_epc, ws_badvaddr, debug_wb_pc, debug_wb_rf_wdata;
  logic [3:0]    debug_wb_rf_wen;

  wb_stage_q #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .NO_EX(NO_EX)) dut (
    .clk(clk), .resetn(resetn),
    .ms_to_ws_valid(ms_to_ws_valid), .ws_allowin(ws_allowin),
    .ms_wen(ms_wen), .ms_dest(ms_dest), .ms_data(ms_data), .ms_pc(ms_pc),
    .ms_ex_code(ms_ex_code), .ms_eret(ms_eret), .ms_slot(ms_slot),
    .ms_badvaddr(ms_badvaddr), .rf_ready(rf_ready),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .fwd_raddr(fwd_raddr), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
    .ws_ex(ws_ex), .ws_eret(ws_eret), .ws_flush(ws_flush),
    .ws_ex_code(ws_ex_code), .ws_epc(ws_epc), .ws_badvaddr(ws_badvaddr),
    .ws_slot(ws_slot), .debug_wb_pc(debug_wb_pc),
    .debug_wb_rf_wen(debug_wb_rf_wen), .debug_wb_rf_wnum(debug_wb_rf_wnum),
    .debug_wb_rf_wdata(debug_wb_rf_wdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          wen;
    logic [AW-1:0] dest;
    logic [DW-1:0] data;
    logic [DW-1:0] pc;
    logic [4:0]    ex;
    logic          eret;
    logic          slot;
    logic [DW-1:0] bad;
  } ent_t;

  // Reference model: pending entries oldest first, plus mode 0=RUN 1=EXC 2=FLUSH.
  ent_t mq[$];
  int   mstate;
  ent_t cur_ent;
  bit   exp_allowin, exp_ret, exp_hexc;
  int   n_pass, n_total;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic ent_t mk(input logic wen, input logic [AW-1:0] dest,
                              input logic [DW-1:0] data, input logic [DW-1:0] pc,
                              input logic [4:0] ex, input logic eret, input logic slot);
    ent_t e;
    e.wen = wen; e.dest = dest; e.data = data; e.pc = pc;
    e.ex = ex; e.eret = eret; e.slot = slot; e.bad = pc ^ 32'h0000_f000;
    return e;
  endfunction

  // Expected outputs from the model and the current inputs.
  task automatic check_outputs();
    bit            run, hp, hexc, ret, we, exc, hit;
    ent_t          h;
    logic [DW-1:0] fd;
    run  = (mstate == 0) && resetn;
    hp   = mq.size() > 0;
    h    = hp ? mq[0] : '0;
    hexc = hp && ((h.ex != NO_EX) || h.eret);
    ret  = run && hp && !hexc && (!h.wen || rf_ready);
    we   = ret && h.wen && (h.dest != '0);
    exp_ret     = ret;
    exp_hexc    = run && hexc;
    exp_allowin = run && ((mq.size() < DEPTH) || ret);
    hit = 1'b0;
    fd  = '0;
    foreach (mq[i])
      if (mq[i].wen && mq[i].dest == fwd_raddr && mq[i].dest != '0 &&
          mq[i].ex == NO_EX && !mq[i].eret) begin
        hit = 1'b1;
        fd  = mq[i].data;
      end
    exc = (mstate == 1) && resetn;
    chk("allowin", ws_allowin, exp_allowin);
    chk("rf_we", rf_we, we);
    if (we) begin
      chk("rf_waddr", rf_waddr, h.dest);
      chk("rf_wdata", rf_wdata, h.data);
    end
    chk("trace_wen", debug_wb_rf_wen, {4{we}});
    if (hp) chk("trace_pc", debug_wb_pc, h.pc);
    chk("fwd_hit", fwd_hit, hit);
    if (hit || !resetn) chk("fwd_data", fwd_data, fd);
    chk("ws_flush", ws_flush, exc);
    chk("ws_ex", ws_ex, exc && (h.ex != NO_EX));
    chk("ws_eret", ws_eret, exc && (h.ex == NO_EX) && h.eret);
    chk("ws_ex_code", ws_ex_code, exc ? h.ex : NO_EX);
    if (exc) begin
      chk("ws_epc", ws_epc, h.slot ? h.pc - 32'd4 : h.pc);
      chk("ws_badvaddr", ws_badvaddr, h.bad);
      chk("ws_slot", ws_slot, h.slot);
    end
    if (!resetn) begin
      chk("rst_rf_wdata", rf_wdata, 0);
      chk("rst_epc", ws_epc, 0);
      chk("rst_trace_pc", debug_wb_pc, 0);
    end
  endtask

  task automatic begin_step(input bit v, input ent_t e, input bit rdy, input logic [AW-1:0] fa);
    ms_to_ws_valid = v;
    ms_wen = e.wen; ms_dest = e.dest; ms_data = e.data; ms_pc = e.pc;
    ms_ex_code = e.ex; ms_eret = e.eret; ms_slot = e.slot; ms_badvaddr = e.bad;
    rf_ready = rdy; fwd_raddr = fa;
    cur_ent = e;
    #4;
    check_outputs();
  endtask

  task automatic end_step();
    bit pushed;
    pushed = ms_to_ws_valid && exp_allowin;
    @(posedge clk);
    if (mstate == 0) begin
      if (exp_ret) void'(mq.pop_front());
      if (pushed) mq.push_back(cur_ent);
      if (exp_hexc) mstate = 1;
    end else if (mstate == 1) begin
      mq.delete();
      mstate = 2;
    end else begin
      mstate = 0;
    end
    $display("t=%0t push=%0d retire=%0d mode=%0d occupancy=%0d", $time, pushed, exp_ret, mstate, mq.size());
    #1;
  endtask

  task automatic step(input bit v, input ent_t e, input bit rdy, input logic [AW-1:0] fa);
    begin_step(v, e, rdy, fa);
    end_step();
  endtask

  ent_t idle, ea, eb;

  initial begin
    n_pass = 0; n_total = 0; mstate = 0;
    idle = mk(1'b0, '0, '0, 32'hbfc0_0000, NO_EX, 1'b0, 1'b0);
    // Reset held: allowin must stay low even with a valid upstream entry.
    resetn = 1'b0;
    ms_to_ws_valid = 1'b1; ms_wen = 1'b1; ms_dest = 5'd3; ms_data = 32'h5a;
    ms_pc = 32'h100; ms_ex_code = NO_EX; ms_eret = 1'b0; ms_slot = 1'b0;
    ms_badvaddr = '0; rf_ready = 1'b1; fwd_raddr = 5'd3;
    #2;
    check_outputs();
    chk("rst_allowin", ws_allowin, 0);
    @(posedge clk); #1;
    resetn = 1'b1;

    // Single write to r3 commits the cycle after it is pushed.
    step(1, mk(1, 5'd3, 32'h11, 32'hbfc0_0000, NO_EX, 0, 0), 1, 5'd3);
    begin_step(0, idle, 1, 5'd3);
    chk("036_we", rf_we, 1);
    chk("036_waddr", rf_waddr, 5'd3);
    chk("036_wdata", rf_wdata, 32'h11);
    end_step();
    begin_step(0, idle, 1, 5'd3);
    chk("036_empty_we", rf_we, 0);
    chk("036_empty_fwd", fwd_hit, 0);
    end_step();

    // Stall the write port, fill the queue, forward youngest, then drain in order.
    step(1, mk(1, 5'd3, 32'haa, 32'hbfc0_0010, NO_EX, 0, 0), 0, 5'd3);
    step(1, mk(1, 5'd3, 32'hbb, 32'hbfc0_0014, NO_EX, 0, 0), 0, 5'd3);
    begin_step(1, mk(1, 5'd4, 32'hcc, 32'hbfc0_0018, NO_EX, 0, 0), 0, 5'd3);
    chk("037_allowin", ws_allowin, 0);
    chk("037_fwd_hit", fwd_hit, 1);
    chk("037_fwd_data", fwd_data, 32'hbb);
    chk("037_no_we", rf_we, 0);
    end_step();
    begin_step(0, idle, 1, 5'd3);
    chk("037_first", rf_wdata, 32'haa);
    end_step();
    begin_step(0, idle, 1, 5'd3);
    chk("037_second", rf_wdata, 32'hbb);
    end_step();
    step(0, idle, 1, 5'd0);

    // Delay-slot exception at the head; the younger entry is discarded.
    step(1, mk(1, 5'd5, 32'h55, 32'hbfc0_0104, 5'h04, 0, 1), 1, 5'd6);
    begin_step(1, mk(1, 5'd6, 32'h66, 32'hbfc0_0108, NO_EX, 0, 0), 1, 5'd6);
    chk("038_no_we", rf_we, 0);
    end_step();
    begin_step(0, idle, 1, 5'd6);
    chk("038_ex", ws_ex, 1);
    chk("038_flush", ws_flush, 1);
    chk("038_epc", ws_epc, 32'hbfc0_0100);
    chk("038_code", ws_ex_code, 5'h04);
    chk("038_no_we_exc", rf_we, 0);
    end_step();
    begin_step(1, mk(1, 5'd7, 32'h77, 32'hbfc0_010c, NO_EX, 0, 0), 1, 5'd6);
    chk("038_flush_allowin", ws_allowin, 0);
    chk("038_flush_pulse", ws_flush, 0);
    end_step();
    begin_step(0, idle, 1, 5'd6);
    chk("038_discarded", rf_we, 0);
    chk("038_allowin_back", ws_allowin, 1);
    end_step();

    // ERET at the head.
    step(1, mk(0, 5'd0, 32'h0, 32'hbfc0_0200, NO_EX, 1, 0), 1, 5'd0);
    step(0, idle, 1, 5'd0);
    begin_step(0, idle, 1, 5'd0);
    chk("039_eret", ws_eret, 1);
    chk("039_ex", ws_ex, 0);
    chk("039_flush", ws_flush, 1);
    end_step();
    step(0, idle, 1, 5'd0);
    begin_step(0, idle, 1, 5'd0);
    chk("039_flush_gone", ws_flush, 0);
    end_step();

    // Push while full and the head retires; repeated to wrap both pointers.
    for (int r = 0; r < 2; r++) begin
      step(1, mk(1, 5'd8, 32'h100 + r, 32'h1000, NO_EX, 0, 0), 0, 5'd8);
      step(1, mk(1, 5'd9, 32'h200 + r, 32'h1004, NO_EX, 0, 0), 0, 5'd8);
      begin_step(1, mk(1, 5'd10, 32'h300 + r, 32'h1008, NO_EX, 0, 0), 1, 5'd10);
      chk("040_allowin_full", ws_allowin, 1);
      chk("040_head", rf_wdata, 32'h100 + r);
      end_step();
      begin_step(0, idle, 1, 5'd10);
      chk("040_fwd_new", fwd_data, 32'h300 + r);
      end_step();
      begin_step(0, idle, 1, 5'd10);
      chk("040_last", rf_wdata, 32'h300 + r);
      end_step();
    end

    // Reset asserted during EXC: immediate reset values, no pulse afterwards.
    step(1, mk(0, 5'd0, 32'h0, 32'hbfc0_0300, 5'h0a, 0, 0), 1, 5'd0);
    step(0, idle, 1, 5'd0);
    resetn = 1'b0;
    ms_to_ws_valid = 1'b1;
    mq.delete();
    mstate = 0;
    #1;
    check_outputs();
    chk("041_flush", ws_flush, 0);
    chk("041_ex", ws_ex, 0);
    chk("041_allowin", ws_allowin, 0);
    @(posedge clk); #1;
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      begin_step(0, idle, 1, 5'd0);
      chk("041_no_pulse", ws_flush, 0);
      end_step();
    end

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      ea = mk($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom,
              $urandom & 32'hffff_fffc,
              ($urandom_range(0, 15) == 0) ? 5'($urandom_range(0, 30)) : NO_EX,
              $urandom_range(0, 31) == 0, $urandom_range(0, 1) == 1);
      step($urandom_range(0, 2) != 0, ea, $urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)));
    end
    eb = idle;
    for (int i = 0; i < 4; i++) step(0, eb, 1, 5'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
